// File: rtl/xi_bus_target_if.sv
// XiBus target pin bundle: CPU-side multiplexed AD bus plus the local register-port handshake.
// slave = the target decoder, master = the CPU/register-file side driving it.
interface xi_bus_target_if;
  logic        adrcyn;
  logic [31:0] ad_i;
  logic        tm1n_i;
  logic        tm0n_i;
  logic [31:0] ad_o;
  logic        ad_oe;
  logic        rdyn_o;
  logic        err_o;
  logic        loc_req;
  logic        loc_we;
  logic [31:0] loc_addr;
  logic [3:0]  loc_wstrb;
  logic [31:0] loc_wdata;
  logic        loc_ack;
  logic [31:0] loc_rdata;

  modport slave (
    input  adrcyn, ad_i, tm1n_i, tm0n_i, loc_ack, loc_rdata,
    output ad_o, ad_oe, rdyn_o, err_o, loc_req, loc_we, loc_addr, loc_wstrb, loc_wdata
  );

  modport master (
    output adrcyn, ad_i, tm1n_i, tm0n_i, loc_ack, loc_rdata,
    input  ad_o, ad_oe, rdyn_o, err_o, loc_req, loc_we, loc_addr, loc_wstrb, loc_wdata
  );
endinterface

// File: rtl/xi_bus_target.sv
// XiBus target decoder: one transfer at a time, bus phases -> local req/ack -> rdyn/err/read data.
// Define XIBUS_TGT_TIMEOUT_EN to bound the local wait to TIMEOUT cycles (err on expiry).
module xi_bus_target #(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter logic [31:0] MASK    = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk,
  input logic            rstn,
  xi_bus_target_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WDATA, LREQ, RESP} state_e;

  typedef struct packed {
    logic       legal;
    logic       we;
    logic [3:0] wstrb;
  } dec_t;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ado_q, ado_d;
  logic        rdyn_q, err_q, oe_q, req_q;
  logic        err_d;
  logic        in_win;
  logic        expired;
  dec_t        dec;

  assign in_win = (({bus.ad_i[31:2], 2'b00} & MASK) == BASE);

  // {tm1n,tm0n,ad[1:0]} -> access type; anything not listed below is illegal
  always_comb begin
    dec = '0;
    case ({bus.tm1n_i, bus.tm0n_i})
      2'b11: dec.legal = (bus.ad_i[1:0] == 2'b00);
      2'b00: begin
        dec.legal = 1'b1;
        dec.we    = 1'b1;
        dec.wstrb = 4'b0001 << bus.ad_i[1:0];
      end
      2'b01: begin
        dec.we = 1'b1;
        case (bus.ad_i[1:0])
          2'b00:   begin dec.legal = 1'b1; dec.wstrb = 4'b1111; end
          2'b01:   begin dec.legal = 1'b1; dec.wstrb = 4'b0011; end
          2'b11:   begin dec.legal = 1'b1; dec.wstrb = 4'b1100; end
          default: dec.legal = 1'b0;
        endcase
      end
      default: dec = '0;
    endcase
  end

`ifdef XIBUS_TGT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;

  // Counter holds the number of completed LREQ cycles; expiry fires in the TIMEOUT-th one
  assign expired = (cnt_q == TW'(TIMEOUT - 1));
  assign cnt_d   = (state_q == LREQ && state_d == LREQ) ? cnt_q + TW'(1) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ado_d   = ado_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.adrcyn && in_win) begin
          if (!dec.legal) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            addr_d  = bus.ad_i[31:2];
            wstrb_d = dec.wstrb;
            we_d    = dec.we;
            state_d = dec.we ? WDATA : LREQ;
          end
        end
      end
      WDATA: begin
        if (bus.adrcyn) begin
          wdata_d = bus.ad_i;
          state_d = LREQ;
        end else if (!in_win) begin
          state_d = IDLE;
        end else if (!dec.legal) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          // Stretched address phase: the latest address wins; a read needs no data phase
          addr_d  = bus.ad_i[31:2];
          wstrb_d = dec.wstrb;
          we_d    = dec.we;
          if (!dec.we) state_d = LREQ;
        end
      end
      LREQ: begin
        if (bus.loc_ack) begin
          state_d = RESP;
          if (!we_q) ado_d = bus.loc_rdata;
        end else if (expired) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-facing outputs are registered off the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ado_q   <= '0;
      rdyn_q  <= 1'b1;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ado_q   <= ado_d;
      rdyn_q  <= (state_d != RESP);
      err_q   <= (state_d == RESP) && err_d;
      oe_q    <= (state_d == RESP) && !err_d && !we_d;
      req_q   <= (state_d == LREQ);
    end
  end

  assign bus.ad_o      = ado_q;
  assign bus.ad_oe     = oe_q;
  assign bus.rdyn_o    = rdyn_q;
  assign bus.err_o     = err_q;
  assign bus.loc_req   = req_q;
  assign bus.loc_we    = we_q;
  assign bus.loc_addr  = {addr_q, 2'b00};
  assign bus.loc_wstrb = wstrb_q;
  assign bus.loc_wdata = wdata_q;

endmodule
